game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter START_LIVES, default 3: lives loaded at game start; legal range 1..3.
REQ-002 Parameter PAUSE_TICKS, default 30: frame ticks spent in each pause state; legal range 1..255.
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle frame strobe; all pause timing counts these strobes.
REQ-006 start_btn  input  1  debounced start button, level-sensitive.
REQ-007 frog_at_top  input  1  frog occupies the top row, level-sensitive.
REQ-008 frog_hit  input  1  frog collided with an obstacle, level-sensitive.
REQ-009 lives  output  2  remaining lives.
REQ-010 state  output  3  current FSM state code.
REQ-011 level_up  output  1  one-cycle pulse that advances the level counter.
REQ-012 reset_level  output  1  one-cycle pulse that returns the level counter to 1.
REQ-013 frog_reset  output  1  one-cycle pulse that respawns the frog at bottom centre.
REQ-014 freeze  output  1  high while obstacles and frog movement are halted.
REQ-015 game_over  output  1  high while in GAME_OVER.

Function
REQ-016 The FSM SHALL have five states with fixed codes: IDLE=0, PLAY=1, LEVEL_UP=2, DEATH=3, GAME_OVER=4.
REQ-017 Internal edge detectors SHALL register start_btn and frog_at_top, giving start_rise and top_rise; both registers reset to 0.
REQ-018 An 8-bit pause counter SHALL increment only on cycles where tick=1 in LEVEL_UP or DEATH; it clears on entry to either state.
REQ-019 In IDLE: freeze=1 and lives=START_LIVES; on start_rise, go to PLAY next cycle and assert reset_level and frog_reset for exactly that one cycle.
REQ-020 In PLAY: freeze=0.
REQ-021 In PLAY with frog_hit=1: go to DEATH and decrement lives, saturating at 0.
REQ-022 In PLAY with top_rise=1 and frog_hit=0: go to LEVEL_UP and pulse level_up for one cycle.
REQ-023 If frog_hit and top_rise are high in the same PLAY cycle, the hit SHALL win: no level_up pulse, enter DEATH.
REQ-024 In LEVEL_UP: freeze=1; when the counter reaches PAUSE_TICKS, pulse frog_reset and return to PLAY.
REQ-025 In DEATH: freeze=1; at PAUSE_TICKS, go to GAME_OVER if lives==0, otherwise pulse frog_reset and return to PLAY.
REQ-026 In GAME_OVER: freeze=1 and game_over=1.
REQ-027 In GAME_OVER on start_rise: reload lives=START_LIVES, pulse reset_level and frog_reset for one cycle, go to PLAY.
REQ-028 start_btn SHALL be ignored in PLAY, LEVEL_UP and DEATH.
REQ-029 frog_hit and frog_at_top SHALL be ignored outside PLAY.
REQ-030 All outputs SHALL be registered.
REQ-031 level_up, reset_level and frog_reset are mutually consistent single-cycle pulses; none is asserted for two consecutive cycles.
REQ-032 If frog_at_top is already high on entering PLAY, no top_rise SHALL occur until it falls and rises again.
REQ-033 Unused state codes 5..7 SHALL transition to IDLE on the next cycle.

Reset
REQ-034 With reset=1 at a clk edge, the next cycle SHALL show: state=IDLE, lives=START_LIVES, freeze=1, game_over=0, level_up=0, reset_level=0, frog_reset=0, pause counter=0.
REQ-035 Reset SHALL take effect from any state, including mid-pause, and SHALL override all other inputs in the same cycle.

Verification
REQ-036 Reset, then start_btn 0->1 -> one cycle later state=1, reset_level=1 and frog_reset=1 for exactly one cycle, freeze=0, lives=3.
REQ-037 PLAY, frog_at_top held high for 10 cycles -> exactly one level_up pulse, state=2; after 30 ticks, frog_reset pulse and state=1.
REQ-038 PLAY, frog_hit and top rise in the same cycle -> no level_up pulse, state=3, lives 3->2.
REQ-039 Three hits, each followed by a 30-tick pause -> lives 2,1,0; after the third pause state=4, game_over=1, freeze=1.
REQ-040 In GAME_OVER, start_btn rise -> lives=3, reset_level pulse, state=1.
REQ-041 In DEATH after 15 ticks, assert reset -> state=0, lives=3; 30 further ticks produce no frog_reset pulse.

Source files
------------

// File: rtl/game_flow_controller.sv
// Game flow FSM for a frogger-style game: it sequences idle, play, level-up pause,
// death pause and game over, and drives the respawn, level and freeze strobes.
module game_flow_controller #(
  parameter int START_LIVES = 3,
  parameter int PAUSE_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       frog_at_top,
  input  logic       frog_hit,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       level_up,
  output logic       reset_level,
  output logic       frog_reset,
  output logic       freeze,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_LEVEL_UP  = 3'd2,
    S_DEATH     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  // The pause ends on the tick that would bring the count up to PAUSE_TICKS.
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_TICKS - 1);

  state_t     cur, nxt;
  logic       start_q, top_q;
  logic       start_rise, top_rise;
  logic [7:0] pause_cnt, cnt_nxt;
  logic [1:0] lives_nxt;
  logic       level_up_nxt, reset_level_nxt, frog_reset_nxt;
  logic       pause_done;

  assign start_rise = start_btn & ~start_q;
  assign top_rise   = frog_at_top & ~top_q;
  assign pause_done = tick && (pause_cnt == PAUSE_LAST);
  assign state      = cur;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt             = cur;
    lives_nxt       = lives;
    cnt_nxt         = pause_cnt;
    level_up_nxt    = 1'b0;
    reset_level_nxt = 1'b0;
    frog_reset_nxt  = 1'b0;
    unique case (cur)
      S_IDLE: begin
        lives_nxt = LIVES_INIT;
        cnt_nxt   = '0;
        if (start_rise) begin
          nxt             = S_PLAY;
          reset_level_nxt = 1'b1;
          frog_reset_nxt  = 1'b1;
        end
      end
      S_PLAY: begin
        cnt_nxt = '0;
        if (frog_hit) begin
          nxt       = S_DEATH;
          lives_nxt = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
        end else if (top_rise) begin
          nxt          = S_LEVEL_UP;
          level_up_nxt = 1'b1;
        end
      end
      S_LEVEL_UP: begin
        if (pause_done) begin
          nxt            = S_PLAY;
          frog_reset_nxt = 1'b1;
          cnt_nxt        = '0;
        end else if (tick) begin
          cnt_nxt = pause_cnt + 8'd1;
        end
      end
      S_DEATH: begin
        if (pause_done) begin
          cnt_nxt = '0;
          if (lives == 2'd0) begin
            nxt = S_GAME_OVER;
          end else begin
            nxt            = S_PLAY;
            frog_reset_nxt = 1'b1;
          end
        end else if (tick) begin
          cnt_nxt = pause_cnt + 8'd1;
        end
      end
      S_GAME_OVER: begin
        cnt_nxt = '0;
        if (start_rise) begin
          nxt             = S_PLAY;
          lives_nxt       = LIVES_INIT;
          reset_level_nxt = 1'b1;
          frog_reset_nxt  = 1'b1;
        end
      end
      default: begin
        nxt       = S_IDLE;
        lives_nxt = LIVES_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cur         <= S_IDLE;
      lives       <= LIVES_INIT;
      pause_cnt   <= '0;
      start_q     <= 1'b0;
      top_q       <= 1'b0;
      level_up    <= 1'b0;
      reset_level <= 1'b0;
      frog_reset  <= 1'b0;
      freeze      <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      cur         <= nxt;
      lives       <= lives_nxt;
      pause_cnt   <= cnt_nxt;
      start_q     <= start_btn;
      top_q       <= frog_at_top;
      level_up    <= level_up_nxt;
      reset_level <= reset_level_nxt;
      frog_reset  <= frog_reset_nxt;
      freeze      <= (nxt != S_PLAY);
      game_over   <= (nxt == S_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed game scenarios with literal expectations,
// then randomized play, all compared every cycle against a rule-level model.
module tb_game_flow_controller;

  localparam int SL = 3;
  localparam int PT = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       frog_at_top = 1'b0;
  logic       frog_hit = 1'b0;
  logic [1:0] lives;
  logic [2:0] state;
  logic       level_up, reset_level, frog_reset, freeze, game_over;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // Reference model: game phase number, lives left, ticks seen in the current pause.
  int m_mode, m_lives, m_ticks;
  bit m_prev_start, m_prev_top;
  bit e_lu, e_rl, e_fr;

  game_flow_controller #(.START_LIVES(SL), .PAUSE_TICKS(PT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn),
    .frog_at_top(frog_at_top), .frog_hit(frog_hit), .lives(lives), .state(state),
    .level_up(level_up), .reset_level(reset_level), .frog_reset(frog_reset),
    .freeze(freeze), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit sr, tr;
    sr = start_btn && !m_prev_start;
    tr = frog_at_top && !m_prev_top;
    e_lu = 0; e_rl = 0; e_fr = 0;
    if (reset) begin
      m_mode = 0; m_lives = SL; m_ticks = 0;
      m_prev_start = 0; m_prev_top = 0;
    end else begin
      m_prev_start = start_btn;
      m_prev_top   = frog_at_top;
      case (m_mode)
        0: begin
          m_lives = SL;
          if (sr) begin m_mode = 1; e_rl = 1; e_fr = 1; end
        end
        1: begin
          m_ticks = 0;
          if (frog_hit) begin
            m_mode = 3;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          end else if (tr) begin
            m_mode = 2; e_lu = 1;
          end
        end
        2, 3: begin
          if (tick) m_ticks++;
          if (m_ticks == PT) begin
            m_ticks = 0;
            if (m_mode == 3 && m_lives == 0) m_mode = 4;
            else begin m_mode = 1; e_fr = 1; end
          end
        end
        default: begin
          if (sr) begin m_mode = 1; m_lives = SL; e_rl = 1; e_fr = 1; end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cmp_en = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", int'(state), m_mode);
      check("lives", int'(lives), m_lives);
      check("level_up", int'(level_up), int'(e_lu));
      check("reset_level", int'(reset_level), int'(e_rl));
      check("frog_reset", int'(frog_reset), int'(e_fr));
      check("freeze", int'(freeze), int'(m_mode != 1));
      check("game_over", int'(game_over), int'(m_mode == 4));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pause_ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset state
    step(); step();
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_freeze", int'(freeze), 1);
    check("rst_game_over", int'(game_over), 0);
    reset = 1'b0;
    step();

    // Start from IDLE
    start_btn = 1'b1; step();
    check("start_state", int'(state), 1);
    check("start_reset_level", int'(reset_level), 1);
    check("start_frog_reset", int'(frog_reset), 1);
    check("start_freeze", int'(freeze), 0);
    check("start_lives", int'(lives), 3);
    step();
    check("start_pulse_width", int'(reset_level) + int'(frog_reset), 0);

    // Frog holds the top row: exactly one level_up, then a full pause
    frog_at_top = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(level_up); end
    check("lvl_pulse_count", cnt, 1);
    check("lvl_state", int'(state), 2);
    pause_ticks(29);
    check("lvl_pause_29", int'(state), 2);
    pause_ticks(1);
    check("lvl_pause_done_state", int'(state), 1);
    check("lvl_pause_frog_reset", int'(frog_reset), 1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); cnt += int'(level_up); end
    check("top_held_no_rise", cnt, 0);
    frog_at_top = 1'b0; step();

    // Hit and top rise together: the hit wins
    frog_hit = 1'b1; frog_at_top = 1'b1; step();
    check("hit_top_state", int'(state), 3);
    check("hit_top_level_up", int'(level_up), 0);
    check("hit_top_lives", int'(lives), 2);
    frog_hit = 1'b0; frog_at_top = 1'b0;
    pause_ticks(PT);
    check("death1_state", int'(state), 1);

    // Two more hits drain the remaining lives
    frog_hit = 1'b1; step(); frog_hit = 1'b0;
    check("hit2_lives", int'(lives), 1);
    pause_ticks(PT);
    frog_hit = 1'b1; step(); frog_hit = 1'b0;
    check("hit3_lives", int'(lives), 0);
    pause_ticks(PT);
    check("go_state", int'(state), 4);
    check("go_flag", int'(game_over), 1);
    check("go_freeze", int'(freeze), 1);

    // Restart from GAME_OVER
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    check("restart_lives", int'(lives), 3);
    check("restart_reset_level", int'(reset_level), 1);
    check("restart_state", int'(state), 1);

    // Reset in the middle of a death pause
    start_btn = 1'b0;
    frog_hit = 1'b1; step(); frog_hit = 1'b0;
    pause_ticks(15);
    reset = 1'b1; step(); reset = 1'b0;
    check("midpause_rst_state", int'(state), 0);
    check("midpause_rst_lives", int'(lives), 3);
    tick = 1'b1;
    cnt = 0;
    for (int i = 0; i < PT; i++) begin step(); cnt += int'(frog_reset); end
    tick = 1'b0;
    check("midpause_no_frog_reset", cnt, 0);
    check("midpause_idle", int'(state), 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 249) == 0);
      tick     = $urandom_range(0, 1) == 1;
      frog_hit = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0)  frog_at_top = ~frog_at_top;
      if ($urandom_range(0, 15) == 0) start_btn = ~start_btn;
      step();
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
